// File: rtl/uart_tx_fifo_arbiter_if.sv
// rtl/uart_tx_fifo_arbiter_if.sv - requester streams and FIFO write port shared by the TX arbiter
interface uart_tx_fifo_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            Req_Valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data;
    logic [NUM_REQ-1:0]            Req_Last;
    logic [NUM_REQ-1:0]            Req_Ready;
    logic                          Fifo_Full;
    logic                          Fifo_Write;
    logic [DATA_WIDTH-1:0]         Fifo_Din;
    logic [ID_W-1:0]               Grant_Id;
    logic                          Busy;

    // Environment side: byte sources plus the FIFO full flag
    modport master (
        output Req_Valid, Req_Data, Req_Last, Fifo_Full,
        input  Req_Ready, Fifo_Write, Fifo_Din, Grant_Id, Busy
    );

    // Arbiter side
    modport slave (
        input  Req_Valid, Req_Data, Req_Last, Fifo_Full,
        output Req_Ready, Fifo_Write, Fifo_Din, Grant_Id, Busy
    );
endinterface

// File: rtl/uart_tx_fifo_arbiter.sv
// rtl/uart_tx_fifo_arbiter.sv - round-robin UART TX FIFO write-port arbiter; ARB_STATS_EN adds byte/stall counters
module uart_tx_fifo_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    uart_tx_fifo_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]             Byte_Count,
    output logic [15:0]             Stall_Count
`endif
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] last_grant;
    logic [7:0]      burst_cnt;
    logic [7:0]      idle_cnt;

    logic            busy;
    logic            cur_valid;
    logic            cur_last;
    logic            xfer;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] cand;

    assign busy      = (state_q == S_GRANT);
    assign cur_valid = bus.Req_Valid[grant_id];
    assign cur_last  = bus.Req_Last[grant_id];
    assign xfer      = busy & cur_valid & ~bus.Fifo_Full;

    assign bus.Busy       = busy;
    assign bus.Grant_Id   = grant_id;
    assign bus.Fifo_Write = xfer;

    // Write port and per-source ready follow the granted source only, and only on a transfer
    always_comb begin
        bus.Fifo_Din  = '0;
        bus.Req_Ready = '0;
        if (xfer) begin
            bus.Fifo_Din  = bus.Req_Data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            bus.Req_Ready = NUM_REQ'(1) << grant_id;
        end
    end

    // Round-robin pick: first valid source after the last granted one, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!pick_found && bus.Req_Valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant FSM: hold a source until Last, burst limit or idle timeout; IDLE always lasts one cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= 8'd0;
            idle_cnt   <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        burst_cnt  <= 8'd0;
                        idle_cnt   <= 8'd0;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        idle_cnt  <= 8'd0;
                        if (cur_last || (burst_cnt == 8'(MAX_BURST - 1))) begin
                            state_q <= S_IDLE;
                        end
                    end else if (!cur_valid) begin
                        // A full-stalled source still has data, so only a missing valid counts as idle
                        idle_cnt <= idle_cnt + 8'd1;
                        if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic stall;
    assign stall = busy & cur_valid & bus.Fifo_Full;

    // Saturating statistics, cleared only by reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Byte_Count  <= 16'd0;
            Stall_Count <= 16'd0;
        end else begin
            if (xfer && (Byte_Count != 16'hFFFF)) begin
                Byte_Count <= Byte_Count + 16'd1;
            end
            if (stall && (Stall_Count != 16'hFFFF)) begin
                Stall_Count <= Stall_Count + 16'd1;
            end
        end
    end
`endif

endmodule
